// File: rtl/mem_pkg.sv
// mem_pkg: shared BRAM geometry defaults and controller state encoding
package mem_pkg;
  localparam int ADDR_W_DEF = 10;
  localparam int DATA_W_DEF = 16;
  typedef enum logic {ST_INIT = 1'b0, ST_RUN = 1'b1} state_e;
endpackage

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: same-address conflict detection with alternating winner
module mem_port_arbiter #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              run,
  input  logic              a_valid,
  input  logic              b_valid,
  input  logic              a_we,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [ADDR_W-1:0] b_addr,
  output logic              a_ready,
  output logic              b_ready
);
  logic conflict, prio_q, prio_d;
  always_comb begin
    conflict = a_valid && b_valid && (a_addr == b_addr) && (a_we || b_we);
    a_ready  = run && !(conflict && prio_q);
    b_ready  = run && !(conflict && !prio_q);
    prio_d   = (run && conflict) ? !prio_q : prio_q;
  end
  // prio_q=0 means A wins the next conflict
  always_ff @(posedge clk)
    if (reset) prio_q <= 1'b0;
    else prio_q <= prio_d;
endmodule

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: dual-requester BRAM controller with post-reset clear sweep
module mem_access_ctrl
  import mem_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int INIT_CLEAR = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              a_valid,
  output logic              a_ready,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_rvalid,
  output logic [DATA_W-1:0] a_rdata,
  input  logic              b_valid,
  output logic              b_ready,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_rvalid,
  output logic [DATA_W-1:0] b_rdata,
  output logic [ADDR_W-1:0] ram_addr_a,
  output logic [DATA_W-1:0] ram_din_a,
  output logic              ram_we_a,
  input  logic [DATA_W-1:0] ram_dout_a,
  output logic [ADDR_W-1:0] ram_addr_b,
  output logic [DATA_W-1:0] ram_din_b,
  output logic              ram_we_b,
  input  logic [DATA_W-1:0] ram_dout_b,
  output logic              init_done
);
  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              a_rv_q, a_rv_d, b_rv_q, b_rv_d;
  logic              run, sweep, a_rdy, b_rdy;
  // reset gates everything combinationally so nothing escapes during reset
  assign run   = (state_q == ST_RUN) && !reset;
  assign sweep = (state_q == ST_INIT) && !reset;
  mem_port_arbiter #(.ADDR_W(ADDR_W)) u_arb (
    .clk(clk), .reset(reset), .run(run),
    .a_valid(a_valid), .b_valid(b_valid), .a_we(a_we), .b_we(b_we),
    .a_addr(a_addr), .b_addr(b_addr), .a_ready(a_rdy), .b_ready(b_rdy)
  );
  always_ff @(posedge clk)
    if (reset) begin
      state_q <= (INIT_CLEAR != 0) ? ST_INIT : ST_RUN;
      cnt_q   <= '0;
      a_rv_q  <= 1'b0;
      b_rv_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_rv_q  <= a_rv_d;
      b_rv_q  <= b_rv_d;
    end
  always_comb begin
    cnt_d   = (state_q == ST_INIT) ? cnt_q + ADDR_W'(1) : cnt_q;
    state_d = (state_q == ST_INIT && cnt_q == '1) ? ST_RUN : state_q;
    a_rv_d  = a_valid && a_rdy && !a_we;
    b_rv_d  = b_valid && b_rdy && !b_we;
  end
  always_comb begin
    a_ready    = a_rdy;
    b_ready    = b_rdy;
    ram_addr_a = sweep ? cnt_q : a_addr;
    ram_din_a  = sweep ? '0 : a_wdata;
    ram_we_a   = sweep || (a_valid && a_rdy && a_we);
    ram_addr_b = b_addr;
    ram_din_b  = b_wdata;
    ram_we_b   = b_valid && b_rdy && b_we;
    a_rvalid   = a_rv_q && !reset;
    b_rvalid   = b_rv_q && !reset;
    a_rdata    = a_rvalid ? ram_dout_a : '0;
    b_rdata    = b_rvalid ? ram_dout_b : '0;
    init_done  = run;
  end
endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl: directed checks of sweep, arbitration, reads and reset
module tb_mem_access_ctrl;
  logic clk = 0, reset = 1, fill = 0;
  logic a_valid = 0, a_we = 0, b_valid = 0, b_we = 0;
  logic [9:0] a_addr = 0, b_addr = 0;
  logic [15:0] a_wdata = 0, b_wdata = 0;
  logic a_ready, b_ready, a_rvalid, b_rvalid, ram_we_a, ram_we_b, init_done;
  logic [15:0] a_rdata, b_rdata, ram_din_a, ram_din_b, dout_a, dout_b;
  logic [9:0] ram_addr_a, ram_addr_b;
  logic [15:0] mem [1024];
  int tests = 0, fails = 0, n;
  always #5 clk = ~clk;
  mem_access_ctrl dut (
    .clk(clk), .reset(reset),
    .a_valid(a_valid), .a_ready(a_ready), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_rvalid(a_rvalid), .a_rdata(a_rdata),
    .b_valid(b_valid), .b_ready(b_ready), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_rvalid(b_rvalid), .b_rdata(b_rdata),
    .ram_addr_a(ram_addr_a), .ram_din_a(ram_din_a), .ram_we_a(ram_we_a), .ram_dout_a(dout_a),
    .ram_addr_b(ram_addr_b), .ram_din_b(ram_din_b), .ram_we_b(ram_we_b), .ram_dout_b(dout_b),
    .init_done(init_done)
  );
  // read-first BRAM model; fill preloads garbage so the clear sweep is observable
  always @(posedge clk) begin
    if (fill) for (int i = 0; i < 1024; i++) mem[i] <= 16'hdead;
    else begin
      if (ram_we_a) mem[ram_addr_a] <= ram_din_a;
      if (ram_we_b) mem[ram_addr_b] <= ram_din_b;
    end
    dout_a <= mem[ram_addr_a];
    dout_b <= mem[ram_addr_b];
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic drive(input logic av, aw, input logic [9:0] aa, input logic [15:0] ad,
                       input logic bv, bw, input logic [9:0] ba, input logic [15:0] bd);
    @(negedge clk);
    a_valid = av; a_we = aw; a_addr = aa; a_wdata = ad;
    b_valid = bv; b_we = bw; b_addr = ba; b_wdata = bd;
    #1;
  endtask
  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
  endtask
  task automatic sweep_wait(output int cycles);
    cycles = 0;
    while (!init_done && cycles < 2000) begin
      @(posedge clk);
      cycles++;
      @(negedge clk);
      #1;
    end
  endtask
  function automatic int nonzero();
    int c = 0;
    for (int i = 0; i < 1024; i++) if (mem[i] != 0) c++;
    return c;
  endfunction
  initial begin
    fill = 1;
    @(negedge clk);
    fill = 0;
    drive(1, 0, 3, 0, 1, 0, 4, 0);
    chk("rst_a_ready", a_ready, 0);
    chk("rst_b_ready", b_ready, 0);
    chk("rst_init_done", init_done, 0);
    chk("rst_ram_we_a", ram_we_a, 0);
    chk("rst_a_rvalid", a_rvalid, 0);
    chk("rst_a_rdata", a_rdata, 0);
    @(negedge clk);
    reset = 0;
    #1;
    chk("sweep_first_addr", ram_addr_a, 0);
    chk("sweep_first_we", ram_we_a, 1);
    chk("sweep_a_ready", a_ready, 0);
    chk("sweep_b_ready", b_ready, 0);
    sweep_wait(n);
    chk("sweep_cycles", n, 1024);
    chk("mem_cleared", nonzero(), 0);
    drive(1, 1, 1, 16'h0002, 0, 0, 0, 0);
    chk("wr_a_ready", a_ready, 1);
    chk("wr_ram_we_a", ram_we_a, 1);
    chk("wr_ram_addr_a", ram_addr_a, 1);
    chk("wr_ram_din_a", ram_din_a, 16'h0002);
    chk("wr_ram_we_b", ram_we_b, 0);
    drive(1, 0, 1, 0, 0, 0, 0, 0);
    chk("wr_no_rvalid", a_rvalid, 0);
    chk("rd_ram_we_a", ram_we_a, 0);
    idle();
    chk("rd_a_rvalid", a_rvalid, 1);
    chk("rd_a_rdata", a_rdata, 16'h0002);
    idle();
    chk("rd_rvalid_once", a_rvalid, 0);
    drive(1, 0, 0, 0, 1, 0, 1, 0);
    chk("dual_a_ready", a_ready, 1);
    chk("dual_b_ready", b_ready, 1);
    idle();
    chk("dual_a_rvalid", a_rvalid, 1);
    chk("dual_b_rvalid", b_rvalid, 1);
    chk("dual_a_rdata", a_rdata, 0);
    chk("dual_b_rdata", b_rdata, 16'h0002);
    drive(1, 0, 513, 0, 1, 0, 1023, 0);
    idle();
    chk("clr_a_rdata", a_rdata, 0);
    chk("clr_b_rdata", b_rdata, 0);
    drive(1, 0, 7, 0, 1, 0, 7, 0);
    chk("rr_same_a_ready", a_ready, 1);
    chk("rr_same_b_ready", b_ready, 1);
    drive(1, 1, 5, 16'h00a1, 1, 1, 5, 16'h00b1);
    chk("c1_a_ready", a_ready, 1);
    chk("c1_b_ready", b_ready, 0);
    chk("c1_ram_we_b", ram_we_b, 0);
    drive(1, 1, 5, 16'h00a2, 1, 1, 5, 16'h00b2);
    chk("c2_a_ready", a_ready, 0);
    chk("c2_b_ready", b_ready, 1);
    chk("c2_ram_we_a", ram_we_a, 0);
    drive(1, 1, 5, 16'h00a3, 1, 1, 5, 16'h00b3);
    chk("c3_a_ready", a_ready, 1);
    chk("c3_b_ready", b_ready, 0);
    drive(0, 0, 0, 0, 1, 0, 5, 0);
    idle();
    chk("c3_readback", b_rdata, 16'h00a3);
    drive(1, 0, 6, 0, 1, 1, 6, 16'h00c4);
    chk("c4_rw_a_ready", a_ready, 0);
    chk("c4_rw_b_ready", b_ready, 1);
    idle();
    chk("c4_lost_read_rvalid", a_rvalid, 0);
    drive(1, 0, 6, 0, 0, 0, 0, 0);
    idle();
    chk("c4_readback", a_rdata, 16'h00c4);
    drive(0, 0, 5, 0, 1, 1, 5, 16'h0077);
    chk("solo_b_ready", b_ready, 1);
    drive(1, 0, 1, 0, 0, 0, 0, 0);
    chk("rst_rd_accept", a_ready, 1);
    @(negedge clk);
    reset = 1; a_valid = 0;
    #1;
    chk("rst_rd_rvalid", a_rvalid, 0);
    chk("rst_rd_init_done", init_done, 0);
    @(negedge clk);
    #1;
    chk("rst_rd_rvalid2", a_rvalid, 0);
    reset = 0;
    #1;
    for (int i = 0; i < 300; i++) begin
      @(posedge clk);
      @(negedge clk);
    end
    #1;
    chk("mid_sweep_addr", ram_addr_a, 300);
    chk("mid_sweep_done", init_done, 0);
    reset = 1;
    @(negedge clk);
    @(negedge clk);
    reset = 0;
    #1;
    chk("restart_addr", ram_addr_a, 0);
    chk("restart_rvalid", a_rvalid, 0);
    sweep_wait(n);
    chk("restart_cycles", n, 1024);
    chk("mem_recleared", nonzero(), 0);
    drive(1, 0, 5, 0, 1, 0, 6, 0);
    idle();
    chk("post_a_rdata", a_rdata, 0);
    chk("post_b_rvalid", b_rvalid, 1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/mem_access_ctrl.md
MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 Parameter ADDR_W, default 10, SHALL set the BRAM word-address width (1024 words).
REQ-002 Parameter DATA_W, default 16, SHALL set the data word width.
REQ-003 Parameter INIT_CLEAR, default 1, SHALL enable the post-reset memory clear sweep when 1.
REQ-004 clk  input  1  clock; reset  input  1  reset, synchronous, active-high; all logic on posedge clk.
REQ-005 a_valid / b_valid  input  1  requester A/B has a request.
REQ-006 a_ready / b_ready  output  1  request accepted this cycle when ready and valid are both high.
REQ-007 a_we / b_we  input  1  1 = write, 0 = read.
REQ-008 a_addr / b_addr  input  ADDR_W  word address.
REQ-009 a_wdata / b_wdata  input  DATA_W  write data.
REQ-010 a_rvalid / b_rvalid  output  1  read data valid.
REQ-011 a_rdata / b_rdata  output  DATA_W  read data.
REQ-012 ram_addr_a / ram_addr_b  output  ADDR_W  BRAM port address.
REQ-013 ram_din_a / ram_din_b  output  DATA_W  BRAM port write data.
REQ-014 ram_we_a / ram_we_b  output  1  BRAM port write enable.
REQ-015 ram_dout_a / ram_dout_b  input  DATA_W  BRAM port read data, valid one cycle after the address is presented.
REQ-016 init_done  output  1  memory sweep complete; requests may be accepted.

Function
REQ-017 Control FSM SHALL have states INIT and RUN; reset enters INIT when INIT_CLEAR=1, otherwise RUN.
REQ-018 INIT SHALL write 0 to addresses 0..2^ADDR_W-1 through port A, one per cycle, ascending, with a_ready=b_ready=0 throughout.
REQ-019 INIT SHALL go to RUN on the cycle after address 2^ADDR_W-1 is written; sweep counter wrap SHALL not re-enter INIT.
REQ-020 init_done SHALL be 1 exactly when the state is RUN.
REQ-021 In RUN, requester A SHALL map to BRAM port A and B to port B; both may be accepted in the same cycle.
REQ-022 Conflict = both valid, equal addresses, and at least one we=1; on conflict only one side SHALL be accepted.
REQ-023 Conflict winner SHALL alternate: A wins the first conflict after reset, and the loser of each conflict wins the next one.
REQ-024 Accepted request SHALL drive ram_addr/ram_din/ram_we combinationally in the same cycle; ram_we SHALL be 0 when nothing is accepted.
REQ-025 An accepted read SHALL assert rvalid for exactly one cycle, the cycle after acceptance, with rdata=ram_dout of that port.
REQ-026 Writes SHALL produce no rvalid.
REQ-027 A read and a write to the same address in the same cycle are a conflict (REQ-022); a read accepted after a write SHALL return the written data.
REQ-028 ready SHALL not depend on its own valid except through conflict detection; ready is high in RUN unless that side loses a conflict.

Reset
REQ-029 reset SHALL clear: a_ready=b_ready=0, a_rvalid=b_rvalid=0, ram_we_a=ram_we_b=0, the sweep counter, the conflict-priority bit (A) and init_done=0; a_rdata/b_rdata SHALL be 0.
REQ-030 reset asserted mid-sweep or mid-read SHALL restart from INIT, and no rvalid SHALL be issued for a request accepted before reset.

Structure
REQ-031 ADDR_W/DATA_W defaults and the INIT/RUN state encoding SHALL live in the shared mem package, reused by memory_FSM.
REQ-032 Conflict detection and priority alternation SHALL be one sub-module, mem_port_arbiter; the BRAM itself SHALL stay outside this block.

Verification
REQ-033 Reset, INIT_CLEAR=1 -> init_done rises after exactly 1024 cycles; each address reads back 0x0000.
REQ-034 A writes 0x0002 to address 1; next cycle A reads address 1 -> a_rvalid one cycle later with a_rdata=0x0002.
REQ-035 A and B read addresses 0 and 1 in the same cycle -> both ready; both rvalid together one cycle later.
REQ-036 Three consecutive A/B write conflicts at address 5 -> winners A, B, A; final read of address 5 returns the last winner's data.
REQ-037 Reset during the sweep at address 300 -> sweep restarts at 0 and init_done stays low for another 1024 cycles.
REQ-038 Read accepted, then reset on the next cycle -> rvalid stays 0.
